// File: rtl/sorted_lists_pkg.sv
// sorted_lists_pkg: shared geometry, types and opcodes for the sorted-list table.
// Types: key_t, id_t, cnt_t, idx_t, op_t, entry_t, table_state_t.
package sorted_lists_pkg;
   localparam int N_ENTRIES = 8;
   localparam int KEY_W     = 16;
   localparam int ID_W      = 8;
   localparam int CNT_W     = $clog2(N_ENTRIES + 1);
   localparam int IDX_W     = $clog2(N_ENTRIES);
   typedef logic [KEY_W-1:0] key_t;
   typedef logic [ID_W-1:0]  id_t;
   typedef logic [CNT_W-1:0] cnt_t;
   typedef logic [IDX_W-1:0] idx_t;
   typedef enum logic [1:0] {INSERT = 2'b00, DELETE = 2'b01, CLEAR = 2'b10, RSVD = 2'b11} op_t;
   typedef struct packed {
      logic vld;
      id_t  id;
      key_t key;
   } entry_t;
   typedef entry_t [N_ENTRIES-1:0] table_state_t;
endpackage

// File: rtl/sorted_lists_lookup.sv
// sorted_lists_lookup: combinational search of the table for a command.
// Ports: tbl (table image), id (command id) -> match_oh/hit (valid entry with id),
//        free_oh (lowest-index invalid slot), and, with SORTED_LISTS_EVICT_EN
//        defined, min_oh/min_key (valid entry with smallest key, lowest index on ties).
module sorted_lists_lookup
   import sorted_lists_pkg::*;
(
   input  table_state_t         tbl,
   input  id_t                  id,
   output logic [N_ENTRIES-1:0] match_oh,
   output logic                 hit,
   output logic [N_ENTRIES-1:0] free_oh
`ifdef SORTED_LISTS_EVICT_EN
   ,
   output logic [N_ENTRIES-1:0] min_oh,
   output key_t                 min_key
`endif
);
   logic taken;
   always_comb begin
      match_oh = '0;
      free_oh  = '0;
      taken    = 1'b0;
      for (int i = 0; i < N_ENTRIES; i++) begin
         match_oh[i] = tbl[i].vld && (tbl[i].id == id);
         free_oh[i]  = !tbl[i].vld && !taken;
         taken       = taken || !tbl[i].vld;
      end
   end
   assign hit = |match_oh;
`ifdef SORTED_LISTS_EVICT_EN
   logic found;
   // Strict less-than keeps the earliest index when keys tie.
   always_comb begin
      min_oh  = '0;
      min_key = '1;
      found   = 1'b0;
      for (int i = 0; i < N_ENTRIES; i++) begin
         if (tbl[i].vld && (!found || tbl[i].key < min_key)) begin
            min_oh    = '0;
            min_oh[i] = 1'b1;
            min_key   = tbl[i].key;
            found     = 1'b1;
         end
      end
   end
`endif
endmodule

// File: rtl/sorted_lists_table.sv
// sorted_lists_table: register-held table of {vld,id,key} entries with insert/delete/clear.
// Ports: clk, rst (async active-low); cmd_vld/cmd_op/cmd_id/cmd_key/cmd_rdy command
//        handshake; rsp_vld/rsp_err completion status; unsorted table image and
//        unsorted_upd change pulse; cnt/full/empty occupancy.
// Optional: SORTED_LISTS_EVICT_EN lets an INSERT on a full table replace the min-key entry.
module sorted_lists_table
   import sorted_lists_pkg::*;
(
   input  logic         clk,
   input  logic         rst,
   input  logic         cmd_vld,
   input  logic [1:0]   cmd_op,
   input  id_t          cmd_id,
   input  key_t         cmd_key,
   output logic         cmd_rdy,
   output logic         rsp_vld,
   output logic         rsp_err,
   output table_state_t unsorted,
   output logic         unsorted_upd,
   output cnt_t         cnt,
   output logic         full,
   output logic         empty
);
   typedef enum logic {S_IDLE, S_CLEAR} state_t;
   state_t               state;
   idx_t                 idx;
   op_t                  op;
   logic [N_ENTRIES-1:0] match_oh, free_oh, evict_oh, wr_oh;
   logic                 hit, evict, err, inc, dec;
   entry_t               wr_e;
`ifdef SORTED_LISTS_EVICT_EN
   logic [N_ENTRIES-1:0] min_oh;
   key_t                 min_key;
   sorted_lists_lookup u_lookup (
      .tbl(unsorted), .id(cmd_id), .match_oh(match_oh), .hit(hit),
      .free_oh(free_oh), .min_oh(min_oh), .min_key(min_key)
   );
   // min_key is only meaningful when full, which is the only case evict is consulted.
   assign evict    = cmd_key > min_key;
   assign evict_oh = min_oh;
`else
   sorted_lists_lookup u_lookup (
      .tbl(unsorted), .id(cmd_id), .match_oh(match_oh), .hit(hit), .free_oh(free_oh)
   );
   assign evict    = 1'b0;
   assign evict_oh = '0;
`endif
   assign op      = op_t'(cmd_op);
   assign full    = cnt == cnt_t'(N_ENTRIES);
   assign empty   = cnt == '0;
   assign cmd_rdy = state == S_IDLE;
   // Upsert takes priority over a fresh slot, which takes priority over eviction.
   assign wr_oh = (op == INSERT) ? (hit ? match_oh : !full ? free_oh : evict ? evict_oh : '0)
                : (op == DELETE) ? match_oh : '0;
   assign wr_e  = (op == INSERT) ? entry_t'{1'b1, cmd_id, cmd_key} : '0;
   assign err   = (op == INSERT) ? (!hit && full && !evict)
                : (op == DELETE) ? !hit : (op == RSVD);
   assign inc   = (op == INSERT) && !hit && !full;
   assign dec   = (op == DELETE) && hit;
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state        <= S_IDLE;
         idx          <= '0;
         unsorted     <= '0;
         cnt          <= '0;
         rsp_vld      <= 1'b0;
         rsp_err      <= 1'b0;
         unsorted_upd <= 1'b0;
      end else begin
         rsp_vld      <= 1'b0;
         rsp_err      <= 1'b0;
         unsorted_upd <= 1'b0;
         if (state == S_CLEAR) begin
            unsorted[idx] <= '0;
            unsorted_upd  <= unsorted[idx].vld;
            cnt           <= cnt - cnt_t'(unsorted[idx].vld);
            idx           <= (idx == idx_t'(N_ENTRIES - 1)) ? '0 : idx + 1'b1;
            if (idx == idx_t'(N_ENTRIES - 1)) begin
               state   <= S_IDLE;
               rsp_vld <= 1'b1;
            end
         end else if (cmd_vld) begin
            for (int i = 0; i < N_ENTRIES; i++)
               if (wr_oh[i]) unsorted[i] <= wr_e;
            cnt          <= cnt + cnt_t'(inc) - cnt_t'(dec);
            unsorted_upd <= |wr_oh;
            rsp_vld      <= op != CLEAR;
            rsp_err      <= err;
            if (op == CLEAR) begin
               state <= S_CLEAR;
               idx   <= '0;
            end
         end
      end
   end
endmodule

// File: tb/tb_sorted_lists_table.sv
// tb_sorted_lists_table: directed and random checks of sorted_lists_table against an array model.
module tb_sorted_lists_table;
   import sorted_lists_pkg::*;
`ifdef SORTED_LISTS_EVICT_EN
   localparam bit EVICT = 1'b1;
`else
   localparam bit EVICT = 1'b0;
`endif
   logic         clk, rst, cmd_vld, cmd_rdy, rsp_vld, rsp_err, unsorted_upd, full, empty;
   logic [1:0]   cmd_op;
   id_t          cmd_id;
   key_t         cmd_key;
   table_state_t unsorted;
   cnt_t         cnt;
   int           n_chk = 0, n_fail = 0;
   bit           m_vld [N_ENTRIES];
   id_t          m_id  [N_ENTRIES];
   key_t         m_key [N_ENTRIES];

   sorted_lists_table dut (
      .clk(clk), .rst(rst), .cmd_vld(cmd_vld), .cmd_op(cmd_op), .cmd_id(cmd_id),
      .cmd_key(cmd_key), .cmd_rdy(cmd_rdy), .rsp_vld(rsp_vld), .rsp_err(rsp_err),
      .unsorted(unsorted), .unsorted_upd(unsorted_upd), .cnt(cnt), .full(full), .empty(empty)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < N_ENTRIES; i++) begin
         m_vld[i] = 1'b0; m_id[i] = '0; m_key[i] = '0;
      end
   endtask

   task automatic check_state(input bit e_vld, input bit e_err, input bit e_upd, input bit e_rdy);
      table_state_t exp_t;
      int           n = 0;
      for (int i = 0; i < N_ENTRIES; i++) begin
         exp_t[i] = entry_t'{m_vld[i], m_id[i], m_key[i]};
         n += int'(m_vld[i]);
      end
      chk("rsp_vld", rsp_vld, e_vld);
      chk("rsp_err", rsp_err, e_err);
      chk("unsorted_upd", unsorted_upd, e_upd);
      chk("cmd_rdy", cmd_rdy, e_rdy);
      chk("cnt", cnt, n);
      chk("full", full, n == N_ENTRIES);
      chk("empty", empty, n == 0);
      chk("table", unsorted, exp_t);
   endtask

   task automatic send(input logic [1:0] op, input int id, input int key);
      int hit = -1, free = -1, mn = -1;
      bit e_err = 0, e_upd = 0;
      cmd_vld = 1'b1; cmd_op = op; cmd_id = id_t'(id); cmd_key = key_t'(key);
      @(posedge clk); #1;
      cmd_vld = 1'b0;
      for (int i = N_ENTRIES - 1; i >= 0; i--) begin
         if (m_vld[i] && m_id[i] == cmd_id) hit = i;
         if (!m_vld[i]) free = i;
         if (m_vld[i] && (mn < 0 || m_key[i] <= m_key[mn])) mn = i;
      end
      if (op == 2'b00) begin
         if (hit >= 0) begin
            m_key[hit] = cmd_key; e_upd = 1;
         end else if (free >= 0) begin
            m_vld[free] = 1; m_id[free] = cmd_id; m_key[free] = cmd_key; e_upd = 1;
         end else if (EVICT && cmd_key > m_key[mn]) begin
            m_vld[mn] = 1; m_id[mn] = cmd_id; m_key[mn] = cmd_key; e_upd = 1;
         end else e_err = 1;
      end else if (op == 2'b01) begin
         if (hit >= 0) begin
            m_vld[hit] = 0; m_id[hit] = '0; m_key[hit] = '0; e_upd = 1;
         end else e_err = 1;
      end else e_err = 1;
      check_state(1'b1, e_err, e_upd, 1'b1);
   endtask

   task automatic idle_cycle();
      @(posedge clk); #1;
      check_state(1'b0, 1'b0, 1'b0, 1'b1);
   endtask

   task automatic run_clear(input bit hold, input int hid, input int hkey);
      bit was;
      cmd_vld = 1'b1; cmd_op = 2'b10;
      @(posedge clk); #1;
      cmd_vld = hold; cmd_op = 2'b00; cmd_id = id_t'(hid); cmd_key = key_t'(hkey);
      check_state(1'b0, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < N_ENTRIES; i++) begin
         @(posedge clk); #1;
         was = m_vld[i];
         m_vld[i] = 0; m_id[i] = '0; m_key[i] = '0;
         check_state(i == N_ENTRIES - 1, 1'b0, was, i == N_ENTRIES - 1);
      end
      if (hold) send(2'b00, hid, hkey);
   endtask

   initial begin
      rst = 1'b0; cmd_vld = 1'b0; cmd_op = '0; cmd_id = '0; cmd_key = '0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check_state(1'b0, 1'b0, 1'b0, 1'b1);
      rst = 1'b1;
      @(posedge clk); #1;
      send(2'b00, 3, 16'h0040);
      send(2'b00, 5, 16'h0100);
      chk("e0", unsorted[0], {1'b1, 8'd3, 16'h0040});
      chk("e1", unsorted[1], {1'b1, 8'd5, 16'h0100});
      send(2'b00, 3, 16'h0200);
      idle_cycle();
      send(2'b01, 3, 0);
      send(2'b01, 3, 0);
      send(2'b00, 9, 16'h0033);
      chk("e0_id9", unsorted[0].id, 8'd9);
      send(2'b11, 9, 0);
      run_clear(1'b0, 0, 0);
      for (int i = 0; i < N_ENTRIES; i++) send(2'b00, 100 + i, i + 1);
      send(2'b00, 20, 5);
      send(2'b00, 21, 0);
      run_clear(1'b1, 42, 7);
      idle_cycle();
      for (int n = 0; n < 300; n++) begin
         int r = $urandom_range(0, 19);
         int id = $urandom_range(0, 11);
         int key = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 8) : $urandom_range(0, 65535);
         if (r < 11) send(2'b00, id, key);
         else if (r < 17) send(2'b01, id, key);
         else if (r < 18) send(2'b11, id, key);
         else if (r < 19) idle_cycle();
         else run_clear($urandom_range(0, 1) == 1, id, key);
      end
      for (int i = 0; i < 5; i++) send(2'b00, 200 + i, 50 + i);
      cmd_vld = 1'b1; cmd_op = 2'b10;
      @(posedge clk); #1;
      cmd_vld = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      #1;
      model_reset();
      check_state(1'b0, 1'b0, 1'b0, 1'b1);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check_state(1'b0, 1'b0, 1'b0, 1'b1);
      send(2'b00, 7, 16'h1234);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/sorted_lists_table.md
# sorted_lists_table

Owns the live contents of the sorted-list table. Accepts insert/delete/clear commands over a valid/ready handshake and holds N entries in registers. Drives the registered table image as `unsorted` directly into `sorting_network`, which returns the key-descending order one cycle later. Reports per-command status and occupancy.

## Interface
Geometry comes from `sorted_lists_pkg` constants; the module has no parameters of its own.
- `N_ENTRIES`, default 8: table depth (entries `e[0..N_ENTRIES-1]`).
- `KEY_W`, default 16: width of `key_t`.
- `ID_W`, default 8: width of `id_t`.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `cmd_vld`  in  1  command valid.
- `cmd_op`  in  2  opcode: 00 INSERT, 01 DELETE, 10 CLEAR, 11 reserved.
- `cmd_id`  in  ID_W  entry identifier.
- `cmd_key`  in  KEY_W  key (INSERT only).
- `cmd_rdy`  out  1  command may be accepted.
- `rsp_vld`  out  1  one-cycle completion pulse.
- `rsp_err`  out  1  status qualifying `rsp_vld`.
- `unsorted`  out  `table_state_t`  registered table image, feeds `sorting_network`.
- `unsorted_upd`  out  1  pulses in the first cycle `unsorted` shows changed content.
- `cnt`  out  $clog2(N_ENTRIES+1)  number of valid entries.
- `full`, `empty`  out  1 each  `cnt==N_ENTRIES` / `cnt==0`.

## Operation
- Entry format is `{vld, id, key}`. An invalid entry always holds `id='0` and `key='0`, so it sinks to the bottom of the descending sort.
- IDs are unique: at most one valid entry per id, enforced by the upsert rule below.
- A command is accepted on a rising edge with `cmd_vld & cmd_rdy`.

Commands:
- **INSERT**
  - Valid entry with matching id: overwrite its key (upsert); `cnt` unchanged.
  - Otherwise, not full: write `{1,id,key}` into the lowest-index invalid slot; `cnt+1`.
  - Otherwise, full: reject with `rsp_err=1` and no change (but see Configuration).
- **DELETE**
  - Matching valid entry: zero it; `cnt-1`.
  - No match: `rsp_err=1`, no change.
  - Remaining entries do not move (no compaction).
- **CLEAR**: enter the CLEAR state and zero one entry per cycle, index 0 upward.
- **Reserved opcode**: `rsp_err=1`, no change.
- `unsorted_upd` pulses only when content actually changed. An upsert with an identical key still counts as a change.

State machine:
- IDLE -> CLEAR on accepted CLEAR. In CLEAR, an index counter runs 0..N_ENTRIES-1.
- CLEAR -> IDLE after the cycle that zeros index N_ENTRIES-1.
- `cmd_rdy` = (state==IDLE); no other stall source.

## Timing
- Reset values: all entries zero, state IDLE, `cmd_rdy=1`, `rsp_vld=0`, `rsp_err=0`, `unsorted_upd=0`, `cnt=0`, `empty=1`, `full=0`.
- Reset asserted mid-CLEAR or mid-command aborts the operation. No `rsp_vld` is produced for it.
- INSERT/DELETE accepted at edge t:
  - Table, `cnt`, `full` and `empty` are updated at t.
  - `rsp_vld`, `rsp_err` and `unsorted_upd` are high for the cycle after t.
  - `sorted_r` from `sorting_network` reflects the change one edge later.
- Back-to-back commands every cycle are sustained, each seeing the previous command's result.
- CLEAR accepted at edge t:
  - Entry i is zeroed at edge t+1+i.
  - `cmd_rdy` is low from t+1 through t+N_ENTRIES.
  - `unsorted_upd` is high in each cycle following an edge that zeroed an entry that was valid.
  - `rsp_vld=1`, `rsp_err=0` in the cycle after the final zeroing edge.
  - CLEAR of an already empty table still takes N_ENTRIES cycles.
- `cnt` is exact every cycle, including during CLEAR.

## Configuration
- Macro: `SORTED_LISTS_EVICT_EN`.
- Defined: an INSERT with no id match on a full table finds the valid entry with the minimum key (lowest index on ties).
  - If `cmd_key` > that minimum: replace the entry with `{1,id,key}`; `cnt` unchanged; `rsp_err=0`.
  - Otherwise: reject with `rsp_err=1`.
- Undefined: a full-table non-matching INSERT is always rejected, and no minimum-search logic is synthesised.

## Structure
- `sorted_lists_pkg` gains:
  - `op_t` enum: INSERT, DELETE, CLEAR, RSVD.
  - `id_t`, alongside the existing `key_t` / `entry_t` / `table_state_t`.
  - `cnt_t`, the count type.
  - Constants `N_ENTRIES`, `KEY_W`, `ID_W`.
- Sub-module `sorted_lists_lookup` is combinational and produces from the table plus `cmd_id`:
  - id-match one-hot and hit flag;
  - lowest-free one-hot;
  - min-key one-hot, present only under `SORTED_LISTS_EVICT_EN`.
- FSM, registers and counters stay in the top module.

## Test plan
- Reset, then INSERT (id 3, key 0x0040), then INSERT (id 5, key 0x0100):
  - `e[0]={1,3,0x40}`, `e[1]={1,5,0x100}`;
  - `cnt=2`;
  - `sorted_r` order is id5, id3, then zeros.
- INSERT id 3 key 0x0200 (upsert): `e[0].key=0x200`, `cnt` stays 2, `rsp_err=0`, `unsorted_upd` pulses once.
- DELETE id 3 -> `e[0]` zeroed, `cnt=1`. DELETE id 3 again -> `rsp_err=1`, no `unsorted_upd`. Then INSERT id 9 -> lands in `e[0]`.
- Fill to 8 entries with keys 1..8, then INSERT id 20 key 5:
  - Without the macro: `rsp_err=1`.
  - With the macro: key-1 entry replaced; a following INSERT with key 0 gives `rsp_err=1`.
- CLEAR on a full table: `cmd_rdy` low for exactly 8 cycles, `cnt` decrements 8→0, single `rsp_vld`. A `cmd_vld` held during CLEAR is accepted in the first IDLE cycle.
- Assert `rst` at the 4th CLEAR cycle -> all outputs at reset values, no `rsp_vld`.
